// File: rtl/conv_filter_pkg.sv
// Shared types and helpers for the KxK convolution engine.
package conv_filter_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_COEF, S_READ, S_DRAIN, S_NORM, S_OUT, S_DONE
   } state_e;

   localparam logic BORDER_ZERO = 1'b0;
   localparam logic BORDER_REPL = 1'b1;

   // Signed accumulator wide enough for K*K products of a signed coef and an unsigned pixel.
   function automatic int acc_width(input int pix_w, input int coef_w, input int k);
      return pix_w + 1 + coef_w + $clog2(k * k);
   endfunction

endpackage

// File: rtl/conv_filter_engine_if.sv
// Control, coefficient, memory and result-stream signals of the convolution engine.
interface conv_filter_engine_if #(
   parameter int PIX_W  = 8,
   parameter int COEF_W = 8,
   parameter int ADDR_W = 16
) ();
   logic              start;
   logic              load_coef;
   logic              border_mode;
   logic              abs_mode;
   logic [3:0]        shift;
   logic              fc_valid;
   logic [COEF_W-1:0] fc;
   logic              rd_en;
   logic [ADDR_W-1:0] addr;
   logic [PIX_W-1:0]  rdata;
   logic [PIX_W-1:0]  out_pixel;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              done;

   modport master (
      output start, load_coef, border_mode, abs_mode, shift, fc_valid, fc, rdata, out_ready,
      input  rd_en, addr, out_pixel, out_valid, busy, done
   );

   modport slave (
      input  start, load_coef, border_mode, abs_mode, shift, fc_valid, fc, rdata, out_ready,
      output rd_en, addr, out_pixel, out_valid, busy, done
   );
endinterface

// File: rtl/conv_tap_addr_gen.sv
// Maps pixel (x,y) and tap index t to a memory address, applying the border policy.
module conv_tap_addr_gen
   import conv_filter_pkg::*;
#(
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int K      = 5,
   parameter int ADDR_W = 16,
   parameter int XW     = 8,
   parameter int YW     = 8,
   parameter int TW     = 5
) (
   input  logic [XW-1:0]     x_i,
   input  logic [YW-1:0]     y_i,
   input  logic [TW-1:0]     t_i,
   input  logic              border_mode_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              in_range_o,
   output logic              issue_o
);
   int cx, cy;

   always_comb begin
      cx = int'(x_i) + int'(t_i) % K - K / 2;
      cy = int'(y_i) + int'(t_i) / K - K / 2;
      in_range_o = (cx >= 0) && (cx < IMG_W) && (cy >= 0) && (cy < IMG_H);
      issue_o    = in_range_o || (border_mode_i == BORDER_REPL);
      // Clamped coordinate is the replicate address; harmless when the tap is not issued.
      if (cx < 0)          cx = 0;
      else if (cx >= IMG_W) cx = IMG_W - 1;
      if (cy < 0)          cy = 0;
      else if (cy >= IMG_H) cy = IMG_H - 1;
      addr_o = ADDR_W'(cy * IMG_W + cx);
   end
endmodule

// File: rtl/conv_filter_engine.sv
// Streaming KxK convolution over a synchronous-read image memory, one result per pixel.
module conv_filter_engine
   import conv_filter_pkg::*;
#(
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int K      = 5,
   parameter int PIX_W  = 8,
   parameter int COEF_W = 8,
   parameter int RD_LAT = 1,
   parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
   input logic                 clk,
   input logic                 rst_n,
   conv_filter_engine_if.slave bus
);
   localparam int TAPS  = K * K;
   localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int TW    = $clog2(TAPS);
   localparam int ACC_W = acc_width(PIX_W, COEF_W, K);
   localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(2 ** PIX_W - 1);

   state_e                   state_q, state_d;
   logic [XW-1:0]            x_q;
   logic [YW-1:0]            y_q;
   logic [TW-1:0]            t_q;
   logic                     border_q, abs_q;
   logic [3:0]               shift_q;
   logic signed [COEF_W-1:0] coef_q [TAPS];
   logic signed [ACC_W-1:0]  acc_q;
   logic [PIX_W-1:0]         pix_q;
   logic                     ovld_q;

   logic [ADDR_W-1:0] tap_addr;
   logic              tap_in_range, tap_issue, tap_vld, tap_use;
   logic              last_tap, drain_end, last_x, last_y, accept;

   // Tap tracking: stage 0 is the issue cycle, stage RD_LAT lines up with rdata.
   logic [RD_LAT:1]           vld_q, use_q;
   logic [RD_LAT:1][TW-1:0]   tidx_q;
   logic [RD_LAT:0]           vld_pipe, use_pipe;
   logic [RD_LAT:0][TW-1:0]   tidx_pipe;

   logic signed [ACC_W-1:0] coef_x, pix_x, prod, acc_base, shifted, mag;
   logic [PIX_W-1:0]        norm_pix;

   conv_tap_addr_gen #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W), .XW(XW), .YW(YW), .TW(TW)
   ) u_tap (
      .x_i(x_q), .y_i(y_q), .t_i(t_q), .border_mode_i(border_q),
      .addr_o(tap_addr), .in_range_o(tap_in_range), .issue_o(tap_issue)
   );

   assign last_tap  = (t_q == TW'(TAPS - 1));
   assign drain_end = (t_q == TW'(RD_LAT - 1));
   assign last_x    = (x_q == XW'(IMG_W - 1));
   assign last_y    = (y_q == YW'(IMG_H - 1));
   assign accept    = ovld_q && bus.out_ready;
   assign tap_use   = tap_in_range || (border_q == BORDER_REPL);

   assign vld_pipe  = {vld_q, tap_vld};
   assign use_pipe  = {use_q, tap_use};
   assign tidx_pipe = {tidx_q, t_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (bus.start) state_d = bus.load_coef ? S_COEF : S_READ;
         S_COEF:  if (bus.fc_valid && last_tap) state_d = S_READ;
         S_READ:  if (last_tap) state_d = S_DRAIN;
         S_DRAIN: if (drain_end) state_d = S_NORM;
         S_NORM:  state_d = S_OUT;
         S_OUT:   if (accept) state_d = (last_x && last_y) ? S_DONE : S_READ;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tap_vld       = 1'b0;
      bus.rd_en     = 1'b0;
      bus.addr      = '0;
      if (state_q == S_READ) begin
         tap_vld   = 1'b1;
         bus.rd_en = tap_issue;
         bus.addr  = tap_issue ? tap_addr : '0;
      end
      bus.busy      = (state_q != S_IDLE);
      bus.done      = (state_q == S_DONE);
      bus.out_pixel = pix_q;
      bus.out_valid = ovld_q;
   end

   always_comb begin
      coef_x   = ACC_W'(coef_q[tidx_pipe[RD_LAT]]);
      pix_x    = $signed(ACC_W'({1'b0, bus.rdata}));
      prod     = use_pipe[RD_LAT] ? coef_x * pix_x : '0;
      acc_base = (tidx_pipe[RD_LAT] == '0) ? '0 : acc_q;
      shifted  = acc_q >>> shift_q;
      mag      = (abs_q && shifted < 0) ? -shifted : shifted;
      if (mag < 0)            norm_pix = '0;
      else if (mag > PIX_MAX) norm_pix = '1;
      else                    norm_pix = mag[PIX_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q      <= '0;
         y_q      <= '0;
         t_q      <= '0;
         border_q <= BORDER_ZERO;
         abs_q    <= 1'b0;
         shift_q  <= '0;
         acc_q    <= '0;
         pix_q    <= '0;
         ovld_q   <= 1'b0;
         vld_q    <= '0;
         use_q    <= '0;
         tidx_q   <= '0;
         for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
      end else begin
         vld_q  <= vld_pipe[RD_LAT-1:0];
         use_q  <= use_pipe[RD_LAT-1:0];
         tidx_q <= tidx_pipe[RD_LAT-1:0];
         if (vld_pipe[RD_LAT]) acc_q <= acc_base + prod;
         unique case (state_q)
            S_IDLE: if (bus.start) begin
               border_q <= bus.border_mode;
               abs_q    <= bus.abs_mode;
               shift_q  <= bus.shift;
               x_q      <= '0;
               y_q      <= '0;
               t_q      <= '0;
            end
            S_COEF: if (bus.fc_valid) begin
               coef_q[t_q] <= bus.fc;
               t_q         <= last_tap ? '0 : t_q + TW'(1);
            end
            S_READ:  t_q <= last_tap ? '0 : t_q + TW'(1);
            S_DRAIN: t_q <= drain_end ? '0 : t_q + TW'(1);
            S_NORM: begin
               pix_q  <= norm_pix;
               ovld_q <= 1'b1;
            end
            S_OUT: if (accept) begin
               ovld_q <= 1'b0;
               x_q    <= last_x ? '0 : x_q + XW'(1);
               if (last_x) y_q <= last_y ? '0 : y_q + YW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_filter_engine.sv
// Directed bench for conv_filter_engine on an 8x8 image, 3x3 kernel, two-cycle memory.
module tb_conv_filter_engine;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   conv_filter_engine_if #(.PIX_W(8), .COEF_W(8), .ADDR_W(6)) bus ();

   conv_filter_engine #(
      .IMG_W(8), .IMG_H(8), .K(3), .PIX_W(8), .COEF_W(8), .RD_LAT(2), .ADDR_W(6)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   logic [7:0] mem [64];
   logic [7:0] rd_p1, rd_p2;
   always @(posedge clk) begin
      rd_p1 <= mem[bus.addr];
      rd_p2 <= rd_p1;
   end
   assign bus.rdata = rd_p2;

   int n_err = 0, n_chk = 0;
   logic signed [7:0] kern [9];
   logic [7:0] out_img [64];
   int   first_cyc, second_cyc, ndone;
   bit   tout, busy_at_done, busy_after_done;
   logic stall_v [5];
   logic [7:0] stall_p [5];
   logic stall_r [5];
   logic post_rd;
   logic [5:0] post_addr;

   task automatic img_ramp(input int off);
      for (int i = 0; i < 64; i++) mem[i] = 8'(i + off);
   endtask

   task automatic img_const(input int v);
      for (int i = 0; i < 64; i++) mem[i] = 8'(v);
   endtask

   task automatic kern_fill(input int center, input int rest);
      for (int i = 0; i < 9; i++) kern[i] = 8'((i == 4) ? center : rest);
   endtask

   // Runs one frame: coefficient feed (with a gap), result collection, optional stall/abort.
   task automatic run_frame(input bit load, input bit border, input bit absm, input logic [3:0] sh,
                            input bit junk_fc, input int stall_idx, input int extra_start,
                            input int abort_pix);
      int cnt = 0, cyc = 0, ci = 0, stall_left = 5, abort_wait = 0;
      bit cap = 0, seen_done = 0, fin = 0;
      tout = 0; ndone = 0; first_cyc = -1; second_cyc = -1;
      busy_at_done = 0; busy_after_done = 1;
      for (int i = 0; i < 64; i++) out_img[i] = 'x;
      @(negedge clk);
      bus.start = 1; bus.load_coef = load; bus.border_mode = border;
      bus.abs_mode = absm; bus.shift = sh; bus.out_ready = 1;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         bus.start = (cyc == extra_start);
         bus.shift = (cyc == extra_start) ? 4'd2 : sh;
         if (load && ci < 9) begin
            if (cyc == 3) bus.fc_valid = 0;
            else begin bus.fc_valid = 1; bus.fc = kern[ci]; ci++; end
         end else if (junk_fc) begin
            bus.fc_valid = 1; bus.fc = 8'h5A;
         end else bus.fc_valid = 0;
         if (cap) begin post_rd = bus.rd_en; post_addr = bus.addr; cap = 0; end
         if (seen_done) begin busy_after_done = bus.busy; fin = 1; end
         if (bus.done) begin
            ndone++;
            if (!seen_done) busy_at_done = bus.busy;
            seen_done = 1;
         end
         if (stall_left > 0 && (stall_left < 5 || (bus.out_valid && cnt == stall_idx))) begin
            bus.out_ready = 0;
            stall_v[5 - stall_left] = bus.out_valid;
            stall_p[5 - stall_left] = bus.out_pixel;
            stall_r[5 - stall_left] = bus.rd_en;
            stall_left--;
         end else begin
            bus.out_ready = 1;
            if (bus.out_valid) begin
               if (cnt < 64) out_img[cnt] = bus.out_pixel;
               if (cnt == 0) first_cyc = cyc;
               if (cnt == 1) second_cyc = cyc;
               if (cnt == stall_idx) cap = 1;
               cnt++;
            end
         end
         if (abort_pix >= 0 && cnt == abort_pix) begin
            abort_wait++;
            if (abort_wait == 3) fin = 1;
         end
         if (cyc > 3000) begin tout = 1; fin = 1; end
      end
      bus.fc_valid = 0; bus.out_ready = 1;
      if (abort_pix < 0) repeat (15) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
   endtask

   task automatic test_reset();
      #1;
      n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      n_chk++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", bus.done); end
      n_chk++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      n_chk++; if (bus.out_pixel !== 8'd0) begin n_err++; $display("FAIL reset_out_pixel got=%0d want=0", bus.out_pixel); end
      n_chk++; if (bus.rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got=%b want=0", bus.rd_en); end
      n_chk++; if (bus.addr !== 6'd0) begin n_err++; $display("FAIL reset_addr got=%0d want=0", bus.addr); end
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_identity();
      img_ramp(0); kern_fill(1, 0);
      run_frame(1, 0, 0, 4'd0, 0, -1, -1, -1);
      n_chk++; if (tout !== 1'b0) begin n_err++; $display("FAIL ident_timeout got=%b want=0", tout); end
      for (int i = 0; i < 64; i++) begin
         n_chk++; if (out_img[i] !== 8'(i)) begin n_err++; $display("FAIL ident_pix[%0d] got=%0d want=%0d", i, out_img[i], i); end
      end
      n_chk++; if (ndone !== 1) begin n_err++; $display("FAIL ident_done_count got=%0d want=1", ndone); end
      n_chk++; if (busy_at_done !== 1'b1) begin n_err++; $display("FAIL ident_busy_at_done got=%b want=1", busy_at_done); end
      n_chk++; if (busy_after_done !== 1'b0) begin n_err++; $display("FAIL ident_busy_after_done got=%b want=0", busy_after_done); end
      n_chk++; if (first_cyc !== 23) begin n_err++; $display("FAIL ident_first_latency got=%0d want=23", first_cyc); end
      n_chk++; if (second_cyc - first_cyc !== 13) begin n_err++; $display("FAIL ident_pixel_period got=%0d want=13", second_cyc - first_cyc); end
   endtask

   task automatic test_ones();
      img_const(10); kern_fill(1, 1);
      run_frame(1, 0, 0, 4'd0, 0, -1, -1, -1);
      n_chk++; if (out_img[0] !== 8'd40) begin n_err++; $display("FAIL ones_zero_00 got=%0d want=40", out_img[0]); end
      n_chk++; if (out_img[3] !== 8'd60) begin n_err++; $display("FAIL ones_zero_30 got=%0d want=60", out_img[3]); end
      n_chk++; if (out_img[27] !== 8'd90) begin n_err++; $display("FAIL ones_zero_33 got=%0d want=90", out_img[27]); end
      n_chk++; if (out_img[63] !== 8'd40) begin n_err++; $display("FAIL ones_zero_77 got=%0d want=40", out_img[63]); end
      run_frame(0, 1, 0, 4'd0, 0, -1, -1, -1);
      for (int i = 0; i < 64; i++) begin
         n_chk++; if (out_img[i] !== 8'd90) begin n_err++; $display("FAIL ones_repl[%0d] got=%0d want=90", i, out_img[i]); end
      end
   endtask

   task automatic test_laplacian();
      img_const(0); mem[27] = 8'd255; kern_fill(8, -1);
      run_frame(1, 0, 0, 4'd0, 0, -1, -1, -1);
      n_chk++; if (out_img[27] !== 8'd255) begin n_err++; $display("FAIL lap_center got=%0d want=255", out_img[27]); end
      n_chk++; if (out_img[26] !== 8'd0) begin n_err++; $display("FAIL lap_left_noabs got=%0d want=0", out_img[26]); end
      n_chk++; if (out_img[0] !== 8'd0) begin n_err++; $display("FAIL lap_far got=%0d want=0", out_img[0]); end
      run_frame(0, 0, 1, 4'd0, 0, -1, -1, -1);
      n_chk++; if (out_img[26] !== 8'd255) begin n_err++; $display("FAIL lap_left_abs got=%0d want=255", out_img[26]); end
      n_chk++; if (out_img[19] !== 8'd255) begin n_err++; $display("FAIL lap_up_abs got=%0d want=255", out_img[19]); end
      n_chk++; if (out_img[27] !== 8'd255) begin n_err++; $display("FAIL lap_center_abs got=%0d want=255", out_img[27]); end
   endtask

   task automatic test_reuse();
      img_const(16); kern_fill(1, 1);
      run_frame(1, 0, 0, 4'd3, 0, -1, -1, -1);
      n_chk++; if (out_img[27] !== 8'd18) begin n_err++; $display("FAIL reuse_load_33 got=%0d want=18", out_img[27]); end
      run_frame(0, 0, 0, 4'd3, 1, -1, -1, -1);
      n_chk++; if (first_cyc !== 13) begin n_err++; $display("FAIL reuse_first_latency got=%0d want=13", first_cyc); end
      n_chk++; if (out_img[27] !== 8'd18) begin n_err++; $display("FAIL reuse_33 got=%0d want=18", out_img[27]); end
      n_chk++; if (out_img[0] !== 8'd8) begin n_err++; $display("FAIL reuse_00 got=%0d want=8", out_img[0]); end
      n_chk++; if (out_img[42] !== 8'd18) begin n_err++; $display("FAIL reuse_25 got=%0d want=18", out_img[42]); end
      n_chk++; if (ndone !== 1) begin n_err++; $display("FAIL reuse_done_count got=%0d want=1", ndone); end
   endtask

   // Image offset 7 so the stalled pixel (2,1) reads 17 through the identity kernel.
   task automatic test_backpressure();
      img_ramp(7); kern_fill(1, 0);
      run_frame(1, 0, 0, 4'd0, 0, 10, -1, -1);
      for (int k = 0; k < 5; k++) begin
         n_chk++; if (stall_v[k] !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got=%b want=1", k, stall_v[k]); end
         n_chk++; if (stall_p[k] !== 8'd17) begin n_err++; $display("FAIL bp_pixel[%0d] got=%0d want=17", k, stall_p[k]); end
         n_chk++; if (stall_r[k] !== 1'b0) begin n_err++; $display("FAIL bp_rd_en[%0d] got=%b want=0", k, stall_r[k]); end
      end
      n_chk++; if (post_rd !== 1'b1) begin n_err++; $display("FAIL bp_resume_rd_en got=%b want=1", post_rd); end
      n_chk++; if (post_addr !== 6'd2) begin n_err++; $display("FAIL bp_resume_addr got=%0d want=2", post_addr); end
      n_chk++; if (out_img[10] !== 8'd17) begin n_err++; $display("FAIL bp_pix10 got=%0d want=17", out_img[10]); end
      n_chk++; if (out_img[11] !== 8'd18) begin n_err++; $display("FAIL bp_pix11 got=%0d want=18", out_img[11]); end
      n_chk++; if (out_img[63] !== 8'd70) begin n_err++; $display("FAIL bp_pix63 got=%0d want=70", out_img[63]); end
   endtask

   task automatic test_reset_midframe();
      bit saw_done = 0;
      img_ramp(0); kern_fill(1, 0);
      run_frame(1, 0, 0, 4'd0, 0, -1, -1, 20);
      n_chk++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before got=%b want=1", bus.busy); end
      #2 rst_n = 0;
      #1;
      n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got=%b want=0", bus.busy); end
      n_chk++; if (bus.rd_en !== 1'b0) begin n_err++; $display("FAIL mid_rd_en got=%b want=0", bus.rd_en); end
      n_chk++; if (bus.addr !== 6'd0) begin n_err++; $display("FAIL mid_addr got=%0d want=0", bus.addr); end
      n_chk++; if (bus.out_pixel !== 8'd0) begin n_err++; $display("FAIL mid_out_pixel got=%0d want=0", bus.out_pixel); end
      n_chk++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid got=%b want=0", bus.out_valid); end
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (20) begin
         @(negedge clk);
         if (bus.done || bus.busy) saw_done = 1;
      end
      n_chk++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL mid_no_done got=%b want=0", saw_done); end
      run_frame(1, 0, 0, 4'd0, 0, -1, 30, -1);
      n_chk++; if (tout !== 1'b0) begin n_err++; $display("FAIL restart_timeout got=%b want=0", tout); end
      for (int i = 0; i < 64; i++) begin
         n_chk++; if (out_img[i] !== 8'(i)) begin n_err++; $display("FAIL restart_pix[%0d] got=%0d want=%0d", i, out_img[i], i); end
      end
      n_chk++; if (ndone !== 1) begin n_err++; $display("FAIL restart_done_count got=%0d want=1", ndone); end
   endtask

   initial begin
      rst_n = 0;
      bus.start = 0; bus.load_coef = 0; bus.border_mode = 0; bus.abs_mode = 0;
      bus.shift = 0; bus.fc_valid = 0; bus.fc = 0; bus.out_ready = 1;
      img_ramp(0);
      test_reset();
      test_identity();
      test_ones();
      test_laplacian();
      test_reuse();
      test_backpressure();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/conv_filter_engine.md
Name: conv_filter_engine

Overview:
Parametrised KxK 2-D convolution engine for the edge-detection datapath. It is the successor to the fixed 5x5 / 256x256 filter.
- Streams one output pixel per image position, in raster order, from a synchronous-read image memory.
- Adds over the 5x5 filter: configurable image size and kernel size, zero or replicate border, output shift, absolute-value mode, coefficient reuse across frames, and out_ready backpressure.

Parameters:
IMG_W, 256, image width in pixels
IMG_H, 256, image height in pixels
K, 5, kernel size (odd, 3..7); taps = K*K
PIX_W, 8, pixel width (unsigned)
COEF_W, 8, coefficient width (signed two's complement)
RD_LAT, 1, memory read latency in cycles (1..4)
ADDR_W, $clog2(IMG_W*IMG_H), address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  frame start pulse; ignored unless in IDLE
load_coef  in  1  sampled with start: 1 = load new K*K coefficients, 0 = reuse stored set
border_mode  in  1  sampled with start: 0 = zero padding, 1 = replicate nearest edge pixel
abs_mode  in  1  sampled with start: 1 = take |result| before clamp
shift  in  4  sampled with start: arithmetic right shift applied to the accumulator
fc_valid  in  1  coefficient strobe
fc  in  COEF_W  coefficient, row-major tap order
rd_en  out  1  memory read strobe
addr  out  ADDR_W  read address, row-major y*IMG_W+x
rdata  in  PIX_W  read data, valid RD_LAT cycles after rd_en
out_pixel  out  PIX_W  result pixel
out_valid  out  1  result valid; held until accepted
out_ready  in  1  downstream accept
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset (async, active-low):
  - State goes to IDLE.
  - out_pixel, out_valid, rd_en, addr, busy and done are all 0.
  - Coefficient store and all pipelines are cleared to 0.
  - Reset mid-frame aborts the frame; no done is produced.
- States: IDLE, COEF, READ, DRAIN, NORM, OUT, DONE.
- IDLE:
  - On start, latch load_coef, border_mode, abs_mode and shift; set pixel coordinates (x,y) to (0,0).
  - Go to COEF if load_coef=1, else to READ.
- COEF:
  - Each fc_valid cycle stores fc into tap[n] and increments n. Gaps in fc_valid are allowed.
  - After the K*K-th store, go to READ.
  - fc_valid in any other state is ignored.
- READ: tap index t runs 0..K*K-1, one tap per cycle, K*K cycles total.
  - Tap offset: dx = t%K - K/2, dy = t/K - K/2. Tap coordinate: (x+dx, y+dy).
  - In range: rd_en=1 and addr = coordinate.
  - Out of range, zero mode: rd_en=0, and the tap contributes 0.
  - Out of range, replicate mode: the coordinate is clamped to [0,IMG_W-1] x [0,IMG_H-1] and rd_en=1.
  - A valid/zero flag and the tap index are delayed RD_LAT cycles so they align with rdata.
  - The accumulator is cleared at t=0 and adds coef[t]*$signed({1'b0,rdata}) (or 0) as each tap returns.
- DRAIN: wait RD_LAT cycles until the last tap has accumulated. rd_en=0.
- NORM (1 cycle), in order:
  - r = acc >>> shift;
  - if abs_mode, r = |r|;
  - clamp to [0, 2^PIX_W-1];
  - register the result into out_pixel and set out_valid=1.
- OUT:
  - Hold out_pixel and out_valid stable while out_ready=0. No reads are issued.
  - On out_valid&&out_ready: clear out_valid and advance x; on x wrap (x = IMG_W-1 to 0), advance y.
  - If the accepted pixel was (IMG_W-1, IMG_H-1), go to DONE; otherwise go to READ.
  - If out_ready is already high on entry, accept in that same cycle.
- DONE: done=1 for one cycle, then go to IDLE.
- Per-pixel latency with out_ready=1: K*K + RD_LAT + 2 cycles.
- Accumulator width: PIX_W+1+COEF_W+$clog2(K*K), signed. No overflow is possible.
- Coefficients persist across frames until reset or the next load_coef=1 frame.

Decomposition:
- conv_filter_pkg holds:
  - state encoding;
  - border-mode constants BORDER_ZERO and BORDER_REPL;
  - accumulator-width function.
- Sub-module conv_tap_addr_gen (combinational): inputs x, y, t, border_mode; outputs addr, in_range, issue.
- The engine instantiates it once.

Test Plan:
Bench parameters: IMG_W=8, IMG_H=8, K=3, RD_LAT=2, image p(x,y)=x+8y unless stated.
1. Identity kernel (tap4=1, rest 0), shift=0, zero mode -> 64 outputs equal to 0..63 in raster order; done pulses exactly once; busy falls the cycle after done.
2. All-ones kernel, constant image 10:
   - zero mode -> (0,0)=40, (3,0)=60, (3,3)=90;
   - replicate mode -> every output is 90.
3. Laplacian (center 8, rest -1), single pixel 255 at (3,3), rest 0:
   - (3,3) -> 2040, clamps to 255;
   - (2,3) -> -255, clamps to 0 with abs_mode=0, or 255 with abs_mode=1.
4. All-ones kernel, constant 16, shift=3, load_coef=0 second frame after a frame with load_coef=1 -> interior = 144>>>3 = 18; no COEF state entered; fc pulses during the frame are ignored.
5. Backpressure: hold out_ready=0 for 5 cycles on pixel (2,1) -> out_valid stays 1, out_pixel stays 17, rd_en stays 0; on release, pixel (3,1) reads begin the next cycle.
6. Reset mid-frame: drop rst_n during READ of pixel 20 -> all outputs 0 asynchronously, no done. Then start with load_coef=1 plus the identity kernel -> correct 64-pixel frame. Also: start while busy is ignored.
